// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - opcodes, ALU functions, FSM states and helpers for cpu_mc
package cpu_mc_pkg;

  localparam logic [3:0] OP_RTYPE  = 4'h0;
  localparam logic [3:0] OP_JMP    = 4'h1;
  localparam logic [3:0] OP_LB     = 4'h2;
  localparam logic [3:0] OP_SB     = 4'h4;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_ANDI   = 4'h6;
  localparam logic [3:0] OP_ORI    = 4'h7;
  localparam logic [3:0] OP_BEQ    = 4'h8;
  localparam logic [3:0] OP_BNE    = 4'h9;
  localparam logic [3:0] OP_BGEZ   = 4'hA;
  localparam logic [3:0] OP_BLTZ   = 4'hB;
  localparam logic [3:0] OP_RTYPE2 = 4'hF;

  localparam logic [2:0] F_ADD   = 3'd0;
  localparam logic [2:0] F_SUB   = 3'd1;
  localparam logic [2:0] F_PASSA = 3'd2;
  localparam logic [2:0] F_XOR   = 3'd3;
  localparam logic [2:0] F_SHL1  = 3'd4;
  localparam logic [2:0] F_AND   = 3'd5;
  localparam logic [2:0] F_OR    = 3'd6;
  localparam logic [2:0] F_SHR1  = 3'd7;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} stateT;

  // 32-bit result so callers can truncate to DW or PCW as needed
  function automatic logic [31:0] sext6(input logic [5:0] v);
    return {{26{v[5]}}, v};
  endfunction

endpackage

// File: rtl/cpu_mc_if.sv
// rtl/cpu_mc_if.sv - data-memory request/ready bus between core and RAM/IO
interface cpu_mc_if #(parameter int DW = 8);
  logic          MREQ;
  logic          MW;
  logic [DW-1:0] MADDR;
  logic [DW-1:0] MDOUT;
  logic [DW-1:0] Din;
  logic          MRDY;

  modport master (output MREQ, MW, MADDR, MDOUT, input Din, MRDY);
  modport slave  (input MREQ, MW, MADDR, MDOUT, output Din, MRDY);
endinterface

// File: rtl/cpu_mc_alu_p.sv
// rtl/cpu_mc_alu_p.sv - combinational ALU with V/C/N/Z flags
module alu_p
  import cpu_mc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]    OP,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [DW-1:0] Y,
  output logic          V,
  output logic          C,
  output logic          N,
  output logic          Z
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // Result and flags; C on SUB is the no-borrow carry of A + ~B + 1
  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} + {1'b0, ~B} + (DW+1)'(1);
    Y = '0;
    V = 1'b0;
    C = 1'b0;
    case (OP)
      F_ADD: begin
        Y = sum[DW-1:0];
        C = sum[DW];
        V = (A[DW-1] == B[DW-1]) && (Y[DW-1] != A[DW-1]);
      end
      F_SUB: begin
        Y = diff[DW-1:0];
        C = diff[DW];
        V = (A[DW-1] != B[DW-1]) && (Y[DW-1] != A[DW-1]);
      end
      F_PASSA: Y = A;
      F_XOR:   Y = A ^ B;
      F_SHL1: begin
        Y = {A[DW-2:0], 1'b0};
        C = A[DW-1];
      end
      F_AND:   Y = A & B;
      F_OR:    Y = A | B;
      F_SHR1: begin
        Y = {1'b0, A[DW-1:1]};
        C = A[0];
      end
      default: Y = '0;
    endcase
    N = Y[DW-1];
    Z = (Y == '0);
  end

endmodule

// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multi-cycle 16-bit-ISA core with memory wait states, timeout fault and HALT/resume
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int DW       = 8,
  parameter int PCW      = 10,
  parameter int WAIT_MAX = 15
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           EN_L,
  input  logic [15:0]    Iin,
  output logic [PCW-1:0] PC,
  cpu_mc_if.master       mem,
  output logic           HALTED,
  output logic           FAULT,
  output logic [DW-1:0]  DataA,
  output logic [DW-1:0]  DataB,
  output logic [DW-1:0]  DataC,
  output logic [DW-1:0]  DataD
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  stateT          state;
  logic [15:0]    IR;
  logic [DW-1:0]  regs [0:7];
  logic           mreqR;
  logic           mwR;
  logic [DW-1:0]  maddrR;
  logic [DW-1:0]  mdoutR;
  logic           prevEN_L;
  logic [CW-1:0]  waitCnt;

  logic [3:0]     opc;
  logic [2:0]     rs, rt, rd, func;
  logic [5:0]     imm6;
  logic [DW-1:0]  rsVal, rtVal, immExt;
  logic           isHalt, isMem;

  logic [2:0]     aluOp;
  logic [DW-1:0]  aluB, aluY;
  logic           aluN, aluZ;
  logic           unusedAluV, unusedAluC;
  logic           wbEn;
  logic [2:0]     wbIdx;
  logic           brTaken;
  logic [PCW-1:0] pcPlus2, brTarget, jmpTarget, execPc;

  assign opc    = IR[15:12];
  assign rs     = IR[11:9];
  assign rt     = IR[8:6];
  assign rd     = IR[5:3];
  assign func   = IR[2:0];
  assign imm6   = IR[5:0];
  assign rsVal  = (rs == 3'd0) ? '0 : regs[rs];
  assign rtVal  = (rt == 3'd0) ? '0 : regs[rt];
  assign immExt = DW'(sext6(imm6));
  assign isHalt = (opc == OP_RTYPE) && (func == F_SUB);
  assign isMem  = (opc == OP_LB) || (opc == OP_SB);

  // Operand/operation select and writeback target for the instruction in IR
  always_comb begin
    aluOp = F_ADD;
    aluB  = rtVal;
    wbEn  = 1'b0;
    wbIdx = rt;
    case (opc)
      OP_RTYPE, OP_RTYPE2: begin
        aluOp = func;
        wbEn  = !isHalt;
        wbIdx = rd;
      end
      OP_ADDI: begin
        aluB = immExt;
        wbEn = 1'b1;
      end
      OP_ANDI: begin
        aluOp = F_AND;
        aluB  = immExt;
        wbEn  = 1'b1;
      end
      OP_ORI: begin
        aluOp = F_OR;
        aluB  = immExt;
        wbEn  = 1'b1;
      end
      OP_LB, OP_SB:     aluB  = immExt;
      OP_BEQ, OP_BNE:   aluOp = F_SUB;
      OP_BGEZ, OP_BLTZ: aluOp = F_PASSA;
      default: ;
    endcase
  end

  alu_p #(.DW(DW)) uAlu (
    .OP(aluOp),
    .A (rsVal),
    .B (aluB),
    .Y (aluY),
    .V (unusedAluV),
    .C (unusedAluC),
    .N (aluN),
    .Z (aluZ)
  );

  assign brTaken = ((opc == OP_BEQ)  &&  aluZ) ||
                   ((opc == OP_BNE)  && !aluZ) ||
                   ((opc == OP_BGEZ) && !aluN) ||
                   ((opc == OP_BLTZ) &&  aluN);

  assign pcPlus2   = PC + PCW'(2);
  assign brTarget  = pcPlus2 + PCW'(sext6(imm6) << 1);
  assign jmpTarget = PCW'({IR[11:0], 1'b0});
  assign execPc    = (opc == OP_JMP) ? jmpTarget : (brTaken ? brTarget : pcPlus2);

  assign mem.MREQ  = mreqR;
  assign mem.MW    = mwR;
  assign mem.MADDR = maddrR;
  assign mem.MDOUT = mdoutR;

  assign DataA = rsVal;
  assign DataB = rtVal;
  assign DataC = (state == S_MEM) ? mem.Din : aluY;
  assign DataD = aluY;

  // Core FSM: fetch, execute/writeback, memory handshake with timeout, halt/resume
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_FETCH;
      PC       <= '0;
      IR       <= '0;
      mreqR    <= 1'b0;
      mwR      <= 1'b0;
      maddrR   <= '0;
      mdoutR   <= '0;
      HALTED   <= 1'b0;
      FAULT    <= 1'b0;
      prevEN_L <= 1'b1;
      waitCnt  <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      prevEN_L <= EN_L;
      case (state)
        S_FETCH: begin
          IR    <= Iin;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (isHalt) begin
            PC     <= pcPlus2;
            HALTED <= 1'b1;
            state  <= S_HALT;
          end else if (isMem) begin
            mreqR   <= 1'b1;
            mwR     <= (opc == OP_SB);
            maddrR  <= aluY;
            mdoutR  <= rtVal;
            waitCnt <= '0;
            state   <= S_MEM;
          end else begin
            if (wbEn && wbIdx != 3'd0) regs[wbIdx] <= aluY;
            PC    <= execPc;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem.MRDY) begin
            if (!mwR && rt != 3'd0) regs[rt] <= mem.Din;
            PC    <= pcPlus2;
            mreqR <= 1'b0;
            mwR   <= 1'b0;
            state <= S_FETCH;
          end else if (waitCnt == CW'(WAIT_MAX - 1)) begin
            // Timeout leaves PC on this instruction so resume retries it
            mreqR  <= 1'b0;
            mwR    <= 1'b0;
            FAULT  <= 1'b1;
            HALTED <= 1'b1;
            state  <= S_HALT;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        S_HALT: begin
          if (prevEN_L && !EN_L) begin
            HALTED <= 1'b0;
            FAULT  <= 1'b0;
            state  <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - directed self-checking bench for cpu_mc with a memory-transaction scoreboard
module tb_cpu_mc;
  import cpu_mc_pkg::*;

  localparam int DW = 8;
  localparam int PCW = 10;
  localparam int WAIT_MAX = 4;

  logic           CLK, RESET, EN_L;
  logic [15:0]    Iin;
  logic [PCW-1:0] PC;
  logic           HALTED, FAULT;
  logic [DW-1:0]  DataA, DataB, DataC, DataD;

  cpu_mc_if #(.DW(DW)) bus ();

  cpu_mc #(.DW(DW), .PCW(PCW), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .RESET(RESET), .EN_L(EN_L), .Iin(Iin), .PC(PC), .mem(bus),
    .HALTED(HALTED), .FAULT(FAULT),
    .DataA(DataA), .DataB(DataB), .DataC(DataC), .DataD(DataD)
  );

  typedef struct {logic mw; logic [7:0] addr; logic [7:0] data;} memTxn;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] rom [512];
  logic [7:0]  memArr [256];
  memTxn       expQ [$];
  memTxn       curTxn;
  int          rdyAfter = 1;
  int          reqCnt = 0;
  bit          mreqSeen = 0;
  logic        lastReq = 0, lastRdy = 0, lastMw = 0;
  logic [7:0]  lastAddr = 0, lastData = 0;

  logic [7:0]  aluExp [8] = '{8'h0E, 8'hEC, 8'hFD, 8'hEC, 8'hFA, 8'h11, 8'hFD, 8'h7E};
  logic [3:0]  brOp [5]   = '{4'h8, 4'h8, 4'h9, 4'hB, 4'hA};
  logic [5:0]  brV [5]    = '{6'h07, 6'h08, 6'h08, 6'h3D, 6'h3D};
  logic [9:0]  brPc [5]   = '{10'h1E, 10'h22, 10'h1E, 10'h1E, 10'h22};

  assign Iin = rom[PC[PCW-1:1]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic resetDut();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    mreqSeen = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic loadNop();
    for (int i = 0; i < 512; i++) rom[i] = 16'h3000;
  endtask

  task automatic pushTxn(input logic mw, input logic [7:0] addr, input logic [7:0] data);
    expQ.push_back('{mw, addr, data});
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                                      input logic [5:0] imm);
    return {op, a, b, imm};
  endfunction

  // Memory responder: MRDY in the rdyAfter-th MREQ cycle (0 = never); scoreboard on each completion
  always @(posedge CLK) begin
    #2;
    if (lastReq && lastRdy) begin
      chk("sb_nonempty", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        curTxn = expQ.pop_front();
        chk("sb_mw", 32'(lastMw), 32'(curTxn.mw));
        chk("sb_addr", 32'(lastAddr), 32'(curTxn.addr));
        if (curTxn.mw) chk("sb_data", 32'(lastData), 32'(curTxn.data));
      end
      if (lastMw) memArr[lastAddr] = lastData;
    end
    if (bus.MREQ) begin
      mreqSeen = 1'b1;
      if (lastReq && !lastRdy) begin
        chk("maddr_hold", 32'(bus.MADDR), 32'(lastAddr));
        chk("mdout_hold", 32'(bus.MDOUT), 32'(lastData));
      end
      reqCnt++;
      bus.MRDY = (rdyAfter != 0) && (reqCnt >= rdyAfter);
      bus.Din  = memArr[bus.MADDR];
    end else begin
      reqCnt   = 0;
      bus.MRDY = 1'b0;
    end
    lastReq  = bus.MREQ;
    lastRdy  = bus.MRDY;
    lastMw   = bus.MW;
    lastAddr = bus.MADDR;
    lastData = bus.MDOUT;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    EN_L = 1'b1;
    bus.MRDY = 1'b0;
    bus.Din = '0;
    for (int i = 0; i < 256; i++) memArr[i] = 8'h00;
    memArr[8'h14] = 8'hA5;
    loadNop();

    // Reset state
    resetDut();
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_mreq", 32'(bus.MREQ), 32'h0);
    chk("rst_mw", 32'(bus.MW), 32'h0);
    chk("rst_halted", 32'(HALTED), 32'h0);
    chk("rst_fault", 32'(FAULT), 32'h0);

    // Store stalled, then asynchronous RESET between edges
    rom[0] = ins(OP_ADDI, 3'd0, 3'd1, 6'h12);
    rom[1] = ins(OP_SB, 3'd0, 3'd1, 6'h03);
    rdyAfter = 0;
    resetDut();
    step(4);
    chk("t1_mreq", 32'(bus.MREQ), 32'h1);
    chk("t1_mw", 32'(bus.MW), 32'h1);
    chk("t1_maddr", 32'(bus.MADDR), 32'h03);
    chk("t1_mdout", 32'(bus.MDOUT), 32'h12);
    #1 RESET = 1'b1;
    #1;
    chk("t1_rst_mreq", 32'(bus.MREQ), 32'h0);
    chk("t1_rst_mw", 32'(bus.MW), 32'h0);
    chk("t1_rst_pc", 32'(PC), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // ADDI r1,r0,-3 then store r1 to observe it
    loadNop();
    rom[0] = 16'h507D;
    rom[1] = ins(OP_SB, 3'd0, 3'd1, 6'h00);
    rom[2] = 16'h0001;
    rdyAfter = 1;
    resetDut();
    step(2);
    chk("t2_pc", 32'(PC), 32'h2);
    chk("t2_no_mreq", 32'(mreqSeen), 32'h0);
    pushTxn(1'b1, 8'h00, 8'hFD);
    step(3);
    chk("t2_sb_pc", 32'(PC), 32'h4);
    chk("t2_sb_mreq", 32'(bus.MREQ), 32'h0);
    step(2);
    chk("t2_halted", 32'(HALTED), 32'h1);

    // Load with 3 wait cycles, then halt at 6, EN_L resume at 8
    loadNop();
    rom[0] = ins(OP_ADDI, 3'd0, 3'd1, 6'h10);
    rom[1] = ins(OP_LB, 3'd1, 3'd2, 6'h04);
    rom[2] = ins(OP_SB, 3'd0, 3'd2, 6'h00);
    rom[3] = 16'h0001;
    rom[4] = ins(OP_ADDI, 3'd0, 3'd3, 6'h05);
    rom[5] = ins(OP_SB, 3'd0, 3'd3, 6'h01);
    rom[6] = 16'h0001;
    rdyAfter = 3;
    resetDut();
    pushTxn(1'b0, 8'h14, 8'h00);
    pushTxn(1'b1, 8'h00, 8'hA5);
    pushTxn(1'b1, 8'h01, 8'h05);
    step(2);
    chk("t3_addi_pc", 32'(PC), 32'h2);
    step(2);
    chk("t3_mreq", 32'(bus.MREQ), 32'h1);
    chk("t3_maddr", 32'(bus.MADDR), 32'h14);
    chk("t3_mw", 32'(bus.MW), 32'h0);
    step(2);
    chk("t3_wait_mreq", 32'(bus.MREQ), 32'h1);
    chk("t3_wait_pc", 32'(PC), 32'h2);
    step(1);
    chk("t3_done_mreq", 32'(bus.MREQ), 32'h0);
    chk("t3_done_pc", 32'(PC), 32'h4);
    EN_L = 1'b0;
    step(5);
    chk("t3_sb_pc", 32'(PC), 32'h6);
    step(2);
    chk("t5_halted", 32'(HALTED), 32'h1);
    chk("t5_pc", 32'(PC), 32'h8);
    step(3);
    chk("t5_low_halted", 32'(HALTED), 32'h1);
    chk("t5_low_pc", 32'(PC), 32'h8);
    EN_L = 1'b1;
    step(2);
    chk("t5_high_halted", 32'(HALTED), 32'h1);
    EN_L = 1'b0;
    step(1);
    chk("t5_resume_halted", 32'(HALTED), 32'h0);
    chk("t5_resume_pc", 32'(PC), 32'h8);
    step(2);
    chk("t5_fetch8_pc", 32'(PC), 32'hA);
    step(5);
    chk("t5_sb_pc", 32'(PC), 32'hC);
    step(2);
    chk("t5_halt2", 32'(HALTED), 32'h1);
    chk("t5_halt2_pc", 32'(PC), 32'hE);
    EN_L = 1'b1;

    // JMP to 0x20 then conditional branch with offset -2
    for (int k = 0; k < 5; k++) begin
      loadNop();
      rom[0] = ins(OP_ADDI, 3'd0, 3'd1, brV[k]);
      rom[1] = ins(OP_ADDI, 3'd0, 3'd2, 6'h07);
      rom[2] = {OP_JMP, 12'h010};
      rom[16'h10] = ins(brOp[k], 3'd1, 3'd2, 6'h3E);
      rom[16'h0F] = 16'h0001;
      rom[16'h11] = 16'h0001;
      resetDut();
      step(6);
      chk("t4_jmp_pc", 32'(PC), 32'h20);
      step(2);
      chk($sformatf("t4_br%0d_pc", k), 32'(PC), 32'(brPc[k]));
      step(2);
      chk($sformatf("t4_br%0d_halt", k), 32'(HALTED), 32'h1);
    end

    // ALU functions via opcode 1111, r0 write discard, ANDI/ORI
    loadNop();
    rom[0] = ins(OP_ADDI, 3'd0, 3'd1, 6'h3D);
    rom[1] = ins(OP_ADDI, 3'd0, 3'd2, 6'h11);
    for (int f = 0; f < 8; f++) begin
      rom[2 + 2*f] = ins(OP_RTYPE2, 3'd1, 3'd2, {3'd3, 3'(f)});
      rom[3 + 2*f] = ins(OP_SB, 3'd0, 3'd3, 6'(f));
      pushTxn(1'b1, 8'(f), aluExp[f]);
    end
    rom[18] = ins(OP_RTYPE, 3'd1, 3'd2, {3'd0, F_ADD});
    rom[19] = ins(OP_SB, 3'd0, 3'd0, 6'h10);
    rom[20] = ins(OP_ANDI, 3'd1, 3'd5, 6'h0F);
    rom[21] = ins(OP_SB, 3'd0, 3'd5, 6'h11);
    rom[22] = ins(OP_ORI, 3'd2, 3'd6, 6'h06);
    rom[23] = ins(OP_SB, 3'd0, 3'd6, 6'h12);
    rom[24] = 16'h0001;
    pushTxn(1'b1, 8'h10, 8'h00);
    pushTxn(1'b1, 8'h11, 8'h0D);
    pushTxn(1'b1, 8'h12, 8'h17);
    rdyAfter = 1;
    resetDut();
    for (int i = 0; i < 200 && !HALTED; i++) step(1);
    chk("alu_halted", 32'(HALTED), 32'h1);
    chk("alu_pc", 32'(PC), 32'h32);

    // Bus timeout with WAIT_MAX=4, then resume retries the store
    loadNop();
    rom[0] = ins(OP_ADDI, 3'd0, 3'd1, 6'h12);
    rom[1] = ins(OP_SB, 3'd0, 3'd1, 6'h03);
    rom[2] = 16'h0001;
    rdyAfter = 0;
    resetDut();
    step(4);
    chk("t6_mreq", 32'(bus.MREQ), 32'h1);
    step(3);
    chk("t6_wait_mreq", 32'(bus.MREQ), 32'h1);
    chk("t6_wait_fault", 32'(FAULT), 32'h0);
    step(1);
    chk("t6_fault", 32'(FAULT), 32'h1);
    chk("t6_halted", 32'(HALTED), 32'h1);
    chk("t6_mreq_off", 32'(bus.MREQ), 32'h0);
    chk("t6_pc", 32'(PC), 32'h2);
    rdyAfter = 1;
    pushTxn(1'b1, 8'h03, 8'h12);
    EN_L = 1'b0;
    step(1);
    chk("t6_resume_fault", 32'(FAULT), 32'h0);
    chk("t6_resume_halted", 32'(HALTED), 32'h0);
    step(3);
    chk("t6_retry_pc", 32'(PC), 32'h4);
    EN_L = 1'b1;
    step(2);
    chk("t6_end_halted", 32'(HALTED), 32'h1);

    chk("sb_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
